// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pipe
//  Description : Pipelined shift/rotate unit (SLL, SRL, SRA, ROL, ROR, PASS).
//                Each stage resolves one binary digit of the shift amount.
//                One operation per cycle over valid/ready, results in order,
//                with a caller tag and a registered zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module shifter_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH):0]   in_amt,
   input  logic [2:0]               in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_zero
);

   localparam int LW = $clog2(WIDTH);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   // Bit offset of stage k's slice in the packed remaining-amount store.
   // Stage k only keeps the amount bits above k (LW-1-k of them), so the
   // store is triangular and each slice shrinks by one bit per stage.
   function automatic int amt_off(input int k);
      int acc;
      acc = 0;
      for (int i = 0; i < k; i++) begin
         acc += LW - 1 - i;
      end
      return acc;
   endfunction

   localparam int AMT_BITS = (LW * (LW - 1)) / 2;

   // ------------------------------------------------------------------
   // Pipeline state. Data/valid/tag exist for every stage (the last one
   // is the output register); direction/fill/amount only feed later
   // stages so the final stage does not hold them.
   // ------------------------------------------------------------------
   logic                r_valid [LW];
   logic [WIDTH-1:0]    r_data  [LW];
   logic [TAG_W-1:0]    r_tag   [LW];
   logic                r_left  [LW-1];
   logic                r_rot   [LW-1];
   logic                r_fill  [LW-1];
   logic [AMT_BITS-1:0] r_amtv;
   logic                r_zero;

   logic                w_adv;
   logic [WIDTH-1:0]    w_pre_data;
   logic [LW-1:0]       w_pre_amt;
   logic                w_pre_left;
   logic                w_pre_rot;
   logic                w_pre_fill;

   // The whole pipe moves only when the output slot is empty or draining.
   assign w_adv    = !r_valid[LW-1] || out_ready;
   assign in_ready = w_adv;

   // Decode the op into direction/rotate/fill and an effective amount.
   // Out-of-range logical shifts are zeroed up front; out-of-range SRA is
   // clamped to WIDTH-1, which already yields all sign bits.
   always_comb begin
      w_pre_data = in_data;
      w_pre_amt  = in_amt[LW-1:0];
      w_pre_left = 1'b0;
      w_pre_rot  = 1'b0;
      w_pre_fill = 1'b0;
      case (in_op)
         OP_SLL: begin
            w_pre_left = 1'b1;
            if (in_amt[LW]) begin
               w_pre_data = '0;
               w_pre_amt  = '0;
            end
         end
         OP_SRL: begin
            if (in_amt[LW]) begin
               w_pre_data = '0;
               w_pre_amt  = '0;
            end
         end
         OP_SRA: begin
            w_pre_fill = in_data[WIDTH-1];
            if (in_amt[LW]) begin
               w_pre_amt = '1;
            end
         end
         OP_ROL: begin
            w_pre_left = 1'b1;
            w_pre_rot  = 1'b1;
         end
         OP_ROR: begin
            w_pre_rot = 1'b1;
         end
         default: begin
            w_pre_amt = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Stage k: shift by 2^k when the current amount bit is set.
   // ------------------------------------------------------------------
   for (genvar k = 0; k < LW; k++) begin : g_stage
      localparam int SH = 1 << k;

      logic             w_v;
      logic [WIDTH-1:0] w_d;
      logic [TAG_W-1:0] w_tag;
      logic             w_left;
      logic             w_rot;
      logic             w_fill;
      logic             w_bit;
      logic [WIDTH-1:0] w_rotl;
      logic [WIDTH-1:0] w_rotr;
      logic [WIDTH-1:0] w_shl;
      logic [WIDTH-1:0] w_shr;
      logic [WIDTH-1:0] w_res;

      if (k == 0) begin : g_head
         assign w_v    = in_valid;
         assign w_d    = w_pre_data;
         assign w_tag  = in_tag;
         assign w_left = w_pre_left;
         assign w_rot  = w_pre_rot;
         assign w_fill = w_pre_fill;
         assign w_bit  = w_pre_amt[0];
      end else begin : g_body
         assign w_v    = r_valid[k-1];
         assign w_d    = r_data[k-1];
         assign w_tag  = r_tag[k-1];
         assign w_left = r_left[k-1];
         assign w_rot  = r_rot[k-1];
         assign w_fill = r_fill[k-1];
         // Lowest bit of the previous stage's remaining amount is ours.
         assign w_bit  = r_amtv[amt_off(k-1)];
      end

      assign w_rotl = {w_d[WIDTH-SH-1:0], w_d[WIDTH-1:WIDTH-SH]};
      assign w_shl  = {w_d[WIDTH-SH-1:0], {SH{1'b0}}};
      assign w_rotr = {w_d[SH-1:0], w_d[WIDTH-1:SH]};
      assign w_shr  = {{SH{w_fill}}, w_d[WIDTH-1:SH]};

      assign w_res = !w_bit ? w_d :
                     (w_left ? (w_rot ? w_rotl : w_shl)
                             : (w_rot ? w_rotr : w_shr));

      // Data, valid and tag advance together; bubbles are held, not collapsed.
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            r_valid[k] <= 1'b0;
            r_data[k]  <= '0;
            r_tag[k]   <= '0;
         end else if (w_adv) begin
            r_valid[k] <= w_v;
            r_data[k]  <= w_res;
            r_tag[k]   <= w_tag;
         end
      end

      if (k < LW - 1) begin : g_ctrl
         localparam int OFF = amt_off(k);
         localparam int RW  = LW - 1 - k;

         logic [RW-1:0] w_rest;

         if (k == 0) begin : g_rest_head
            assign w_rest = w_pre_amt[LW-1:1];
         end else begin : g_rest_body
            assign w_rest = r_amtv[amt_off(k-1)+LW-k-1 : amt_off(k-1)+1];
         end

         // Direction, fill and the not-yet-consumed amount bits travel on.
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               r_left[k]             <= 1'b0;
               r_rot[k]              <= 1'b0;
               r_fill[k]             <= 1'b0;
               r_amtv[OFF+RW-1:OFF]  <= '0;
            end else if (w_adv) begin
               r_left[k]             <= w_left;
               r_rot[k]              <= w_rot;
               r_fill[k]             <= w_fill;
               r_amtv[OFF+RW-1:OFF]  <= w_rest;
            end
         end
      end

      if (k == LW - 1) begin : g_tail
         // Zero flag is registered alongside the output data it describes.
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               r_zero <= 1'b0;
            end else if (w_adv) begin
               r_zero <= (w_res == '0);
            end
         end
      end
   end

   assign out_valid = r_valid[LW-1];
   assign out_data  = r_data[LW-1];
   assign out_tag   = r_tag[LW-1];
   assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shifter_pipe
//  Description : Self-checking bench for shifter_pipe (WIDTH=8, TAG_W=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shifter_pipe;

   localparam int WIDTH = 8;
   localparam int TAG_W = 4;
   localparam int LAT   = 3;

   logic             clk = 1'b0;
   logic             nrst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [3:0]       in_amt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;

   always #5 clk = ~clk;

   shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_zero  (out_zero)
   );

   typedef struct {
      logic [7:0] data;
      logic [3:0] tag;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [2:0] op;
      logic [7:0] d;
      logic [3:0] amt;
      logic [3:0] tag;
      logic [7:0] exp;
   } vec_t;

   exp_t       q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   logic       check_lat;
   logic       stall_prev;
   logic [7:0] prev_data;
   logic [3:0] prev_tag;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on the operand, independent of stage structure.
   function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] d, input int amt);
      logic [15:0] dd;
      int          r;
      int          sv;
      dd = {d, d};
      r  = amt % 8;
      sv = d[7] ? (int'(d) - 256) : int'(d);
      if (op == 3'd0) return (amt >= 8) ? 8'h00 : 8'((int'(d) * (1 << amt)) % 256);
      if (op == 3'd1) return (amt >= 8) ? 8'h00 : 8'(int'(d) / (1 << amt));
      if (op == 3'd2) return 8'(sv >>> amt);
      if (op == 3'd3) begin dd = dd << r; return dd[15:8]; end
      if (op == 3'd4) begin dd = dd >> r; return dd[7:0]; end
      return d;
   endfunction

   // One clock cycle: drive at negedge, check, update the model, wait posedge.
   task automatic step(input logic iv, input logic [2:0] op, input logic [7:0] d,
                       input logic [3:0] amt, input logic [3:0] tag, input logic ordy,
                       input logic use_tab, input logic [7:0] tab_exp,
                       output logic ov, output logic ir);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      in_op     = op;
      in_data   = d;
      in_amt    = amt;
      in_tag    = tag;
      out_ready = ordy;
      #1;
      ov = out_valid;
      ir = in_ready;
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, prev_data);
         chk("stall_tag", out_tag, prev_tag);
      end
      if (out_valid) begin
         chk("zero_flag", out_zero, out_data == 8'h00);
         if (q.size() == 0) begin
            chk("spurious_valid", out_valid, 0);
         end else if (out_ready) begin
            e = q.pop_front();
            chk("data", out_data, e.data);
            chk("tag", out_tag, e.tag);
            if (check_lat) chk("latency", cyc - e.cyc, LAT);
         end
      end
      if (iv && in_ready) begin
         e.data = use_tab ? tab_exp : ref_op(op, d, int'(amt));
         e.tag  = tag;
         e.cyc  = cyc;
         q.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      @(posedge clk);
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tab[14];
      logic       ov;
      logic       ir;
      int         accepted;
      int         n;
      int         seen;
      logic       riv;
      logic [2:0] rop;

      tab[0]  = '{3'd2, 8'h96, 4'd3,  4'h1, 8'hF2};
      tab[1]  = '{3'd1, 8'h96, 4'd3,  4'h2, 8'h12};
      tab[2]  = '{3'd0, 8'h96, 4'd3,  4'h3, 8'hB0};
      tab[3]  = '{3'd3, 8'h96, 4'd3,  4'h4, 8'hB4};
      tab[4]  = '{3'd4, 8'h96, 4'd11, 4'h5, 8'hD2};
      tab[5]  = '{3'd4, 8'h96, 4'd8,  4'h6, 8'h96};
      tab[6]  = '{3'd0, 8'h96, 4'd9,  4'h7, 8'h00};
      tab[7]  = '{3'd2, 8'h96, 4'd12, 4'h8, 8'hFF};
      tab[8]  = '{3'd2, 8'h16, 4'd15, 4'h9, 8'h00};
      tab[9]  = '{3'd5, 8'h5A, 4'd7,  4'hA, 8'h5A};
      tab[10] = '{3'd7, 8'hC3, 4'd0,  4'hB, 8'hC3};
      tab[11] = '{3'd1, 8'h81, 4'd0,  4'hC, 8'h81};
      tab[12] = '{3'd3, 8'h81, 4'd4,  4'hD, 8'h18};
      tab[13] = '{3'd0, 8'h01, 4'd7,  4'hE, 8'h80};

      nrst = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_data = 8'h00;
      in_amt = 4'd0; in_tag = 4'h0; out_ready = 1'b0;
      check_lat = 1'b0; stall_prev = 1'b0; prev_data = 8'h00; prev_tag = 4'h0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_tag", out_tag, 0);
      chk("reset_out_zero", out_zero, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #2 nrst = 1'b1;

      // Directed table, streamed back-to-back with no stalls
      check_lat = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step(1'b1, tab[i].op, tab[i].d, tab[i].amt, tab[i].tag, 1'b1, 1'b1, tab[i].exp, ov, ir);
      end
      repeat (LAT + 2) step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b1, 1'b0, 8'h00, ov, ir);
      chk("table_drained", q.size(), 0);

      // Randomized stream with gaps and random back-pressure
      check_lat = 1'b0;
      accepted  = 0;
      n         = 0;
      while (accepted < 20 && n < 500) begin
         riv = ($urandom_range(0, 3) != 0);
         rop = 3'($urandom_range(0, 7));
         step(riv, rop, 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'b0, 8'h00, ov, ir);
         if (riv && ir) accepted++;
         n++;
      end
      chk("random_accepted", accepted, 20);
      n = 0;
      while (q.size() > 0 && n < 50) begin
         step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b1, 1'b0, 8'h00, ov, ir);
         n++;
      end
      chk("random_drained", q.size(), 0);

      // Fill under back-pressure, then drain on consecutive cycles
      step(1'b1, 3'd0, 8'h11, 4'd1, 4'h1, 1'b0, 1'b0, 8'h00, ov, ir);
      step(1'b1, 3'd4, 8'h11, 4'd1, 4'h2, 1'b0, 1'b0, 8'h00, ov, ir);
      step(1'b1, 3'd2, 8'h80, 4'd2, 4'h3, 1'b0, 1'b0, 8'h00, ov, ir);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b0, 1'b0, 8'h00, ov, ir);
         chk("full_out_valid", ov, 1);
         chk("full_in_ready", ir, 0);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b1, 1'b0, 8'h00, ov, ir);
         chk("drain_consecutive", ov, 1);
      end
      step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b1, 1'b0, 8'h00, ov, ir);
      chk("drain_done", ov, 0);
      chk("stall_drained", q.size(), 0);

      // Asynchronous reset mid-cycle with operations in flight
      step(1'b1, 3'd0, 8'h0F, 4'd1, 4'h3, 1'b0, 1'b0, 8'h00, ov, ir);
      step(1'b1, 3'd1, 8'hF0, 4'd1, 4'h4, 1'b0, 1'b0, 8'h00, ov, ir);
      step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b0, 1'b0, 8'h00, ov, ir);
      #3;
      chk("pre_reset_valid", out_valid, 1);
      nrst = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_tag", out_tag, 0);
      chk("async_rst_zero", out_zero, 0);
      q.delete();
      stall_prev = 1'b0;
      @(posedge clk);
      #2 nrst = 1'b1;

      check_lat = 1'b1;
      seen = 0;
      step(1'b1, 3'd3, 8'h5A, 4'd2, 4'hA, 1'b1, 1'b0, 8'h00, ov, ir);
      if (ov) seen++;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 3'd0, 8'h00, 4'd0, 4'h0, 1'b1, 1'b0, 8'h00, ov, ir);
         if (ov) seen++;
      end
      chk("post_reset_results", seen, 1);
      chk("post_reset_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
